cpu_datapath: RTL and testbench
===============================

// Module: cpu_datapath
// PURPOSE
//  Register/datapath end of the control_unit interface: holds FSM state, PC, IR, A, B, ALU result and ZF.
//  Consumes control_unit's next_state and control strobes; returns state, instr and zf to it.
//  Drives the single-port memory: address mux, write data, write strobe.
//  All updates occur on the rising edge of clk; the datapath introduces no extra pipelining.
// PARAMETERS
//  DATA_W    8      data/register width; the ALU and ZF operate on DATA_W bits
//  ADDR_W    8      PC and memory address width
//  RESET_PC  0      PC value loaded on reset
// PORTS
//  clk         in   1       system clock
//  reset       in   1       synchronous, active-high reset
//  next_state  in   3       next FSM state from control_unit
//  ctrl        in   26      packed control word from control_unit (layout in cpu_pkg)
//  state       out  3       current FSM state register
//  instr       out  8       instruction register (IR)
//  zf          out  1       zero-flag register
//  mem_addr    out  ADDR_W  memory address (combinational mux)
//  mem_wdata   out  DATA_W  memory write data (combinational mux)
//  mem_rdata   in   DATA_W  memory read data, valid in the same cycle as mem_addr
//  mem_wr      out  1       memory write strobe
//  halted      out  1       sticky halt indicator
//  step        in   1       single-step enable; present only with CPU_SINGLE_STEP_EN
// BEHAVIOUR
//  ctrl layout: pc_we[25] pc_sel[24] pc_offset[23:20] addr_sel[19] addr_offset[18:15] mem_sel[14]
//   mem_we[13] alu_opcode[12:10] alu_sel_a[9] alu_sel_b[8] alu_we[7] zf_we[6] ir_we[5] a_sel[4]
//   a_we[3] b_sel[2] b_we[1] halt[0].
//  Reset: state=FETCH(000), PC=RESET_PC, IR=0, A=0, B=0, ALU_R=0, zf=0, halted=0.
//   Reset overrides every other input in the same cycle.
//  State: state<=next_state each enabled cycle. If halt=1 or halted=1, state<=HALT_STATE(101).
//  PC (pc_we=1): pc_sel=0 -> PC+1; pc_sel=1 -> PC+sext(pc_offset). Result wraps mod 2^ADDR_W.
//  mem_addr: addr_sel=0 -> PC; addr_sel=1 -> B+zext(addr_offset). Result wraps mod 2^ADDR_W.
//  mem_wdata: mem_sel=0 -> A; mem_sel=1 -> B.
//  mem_wr = mem_we & ~halt & ~halted & enable. This is the only combinational output gating.
//  IR: ir_we=1 -> IR<=mem_rdata.
//  ALU operands: opA = alu_sel_a ? PC : A; opB = alu_sel_b ? zext(IR[3:0]) : B.
//  ALU ops: 000 ADD, 001 SUB(opA-opB), 010 AND, 011 OR, 100 XOR, 101 NOT opA, 110 SHL1 opA, 111 SHR1 opA.
//   Carry/borrow is discarded; results wrap mod 2^DATA_W.
//  alu_we=1 -> ALU_R<=result. zf_we=1 -> zf<=(result==0). Each is independent of the other.
//  A: a_we=1 -> A<=(a_sel ? mem_rdata : ALU_R). B: b_we=1 -> B<=(b_sel ? mem_rdata : ALU_R).
//   In the same cycle, alu_we plus a_we with a_sel=0 loads the OLD ALU_R into A.
//  Halt: halt=1 sets halted on the next edge. All register writes and mem_wr are suppressed
//   from the halt=1 cycle onward. halted clears only on reset.
//  All register writes are independent; any combination may fire in one cycle.
// CONFIGURATION
//  CPU_SINGLE_STEP_EN defined: step port exists and enable=step. With step=0, every register
//   (including state) holds and mem_wr=0.
//  CPU_SINGLE_STEP_EN undefined: no step port; enable is tied to 1.
//  Reset is never gated by enable.
// STRUCTURE
//  cpu_pkg: FSM state localparams (FETCH..HALT_STATE), ALU opcode localparams, ctrl bit/field
//   index localparams. These are shared with control_unit.
//  Sub-module cpu_alu: combinational; inputs opA, opB, opcode; outputs result and zero.
//   Everything else stays in cpu_datapath.
// TESTING
//  reset=1 for 2 cycles with ctrl=all-ones -> state=000, PC=0, IR/A/B/zf=0, mem_wr=0, halted=0.
//  mem_rdata=8'h2A, ir_we=1, pc_we=1, pc_sel=0 -> next edge: IR=8'h2A, PC=1.
//  A=8'h05, B=8'h05, SUB with alu_we and zf_we -> ALU_R=0, zf=1. Then a_we, a_sel=0 -> A=0.
//  PC=8'hFF, pc_we=1, pc_sel=0 -> PC=8'h00. PC=8'h02, pc_sel=1, pc_offset=4'hE -> PC=8'h00.
//  B=8'hFE, addr_sel=1, addr_offset=3, mem_we=1, mem_sel=0, A=8'h77 -> mem_addr=8'h01, mem_wdata=8'h77, mem_wr=1.
//  halt=1 with a_we=1, mem_we=1 -> A unchanged, mem_wr=0. Then state=101, halted=1 until reset.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the CPU datapath and control_unit: FSM states, ALU opcodes, ctrl word layout.
package cpu_pkg;

    localparam int STATE_W = 3;
    localparam int CTRL_W  = 26;

    localparam logic [2:0] FETCH      = 3'd0;
    localparam logic [2:0] DECODE     = 3'd1;
    localparam logic [2:0] EXECUTE    = 3'd2;
    localparam logic [2:0] MEM_ACCESS = 3'd3;
    localparam logic [2:0] WRITEBACK  = 3'd4;
    localparam logic [2:0] HALT_STATE = 3'd5;

    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;
    localparam logic [2:0] ALU_AND = 3'd2;
    localparam logic [2:0] ALU_OR  = 3'd3;
    localparam logic [2:0] ALU_XOR = 3'd4;
    localparam logic [2:0] ALU_NOT = 3'd5;
    localparam logic [2:0] ALU_SHL = 3'd6;
    localparam logic [2:0] ALU_SHR = 3'd7;

    // Bit / field positions inside the ctrl word
    localparam int CTRL_PC_WE      = 25;
    localparam int CTRL_PC_SEL     = 24;
    localparam int CTRL_PC_OFF_HI  = 23;
    localparam int CTRL_PC_OFF_LO  = 20;
    localparam int CTRL_ADDR_SEL   = 19;
    localparam int CTRL_ADDR_OFF_HI = 18;
    localparam int CTRL_ADDR_OFF_LO = 15;
    localparam int CTRL_MEM_SEL    = 14;
    localparam int CTRL_MEM_WE     = 13;
    localparam int CTRL_ALU_OP_HI  = 12;
    localparam int CTRL_ALU_OP_LO  = 10;
    localparam int CTRL_ALU_SEL_A  = 9;
    localparam int CTRL_ALU_SEL_B  = 8;
    localparam int CTRL_ALU_WE     = 7;
    localparam int CTRL_ZF_WE      = 6;
    localparam int CTRL_IR_WE      = 5;
    localparam int CTRL_A_SEL      = 4;
    localparam int CTRL_A_WE       = 3;
    localparam int CTRL_B_SEL      = 2;
    localparam int CTRL_B_WE       = 1;
    localparam int CTRL_HALT       = 0;

    typedef struct packed {
        logic       pc_we;
        logic       pc_sel;
        logic [3:0] pc_offset;
        logic       addr_sel;
        logic [3:0] addr_offset;
        logic       mem_sel;
        logic       mem_we;
        logic [2:0] alu_opcode;
        logic       alu_sel_a;
        logic       alu_sel_b;
        logic       alu_we;
        logic       zf_we;
        logic       ir_we;
        logic       a_sel;
        logic       a_we;
        logic       b_sel;
        logic       b_we;
        logic       halt;
    } ctrl_t;

endpackage

// File: rtl/cpu_alu.sv
// Combinational ALU: eight single-cycle operations, carry/borrow discarded, plus a zero flag.
module cpu_alu
    import cpu_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic [DATA_W-1:0] op_a,
    input  logic [DATA_W-1:0] op_b,
    input  logic [2:0]        opcode,
    output logic [DATA_W-1:0] result,
    output logic              zero
);

    always_comb begin
        result = '0;
        case (opcode)
            ALU_ADD: result = op_a + op_b;
            ALU_SUB: result = op_a - op_b;
            ALU_AND: result = op_a & op_b;
            ALU_OR:  result = op_a | op_b;
            ALU_XOR: result = op_a ^ op_b;
            ALU_NOT: result = ~op_a;
            ALU_SHL: result = {op_a[DATA_W-2:0], 1'b0};
            ALU_SHR: result = {1'b0, op_a[DATA_W-1:1]};
            default: result = '0;
        endcase
    end

    assign zero = (result == '0);

endmodule

// File: rtl/cpu_datapath.sv
// Register/datapath half of the CPU: state, PC, IR, A, B, ALU_R, ZF, memory address/data muxes.
// Optional feature macro: CPU_SINGLE_STEP_EN adds a step port that gates every register update.
module cpu_datapath
    import cpu_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 8,
    parameter int RESET_PC = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [2:0]        next_state,
    input  logic [25:0]       ctrl,
    output logic [2:0]        state,
    output logic [7:0]        instr,
    output logic              zf,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
`ifdef CPU_SINGLE_STEP_EN
    input  logic              step,
`endif
    output logic              mem_wr,
    output logic              halted
);

    ctrl_t c;
    logic  en;
    logic  blocked;
    logic  wr_en;

    logic [2:0]        state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [7:0]        ir_q, ir_d;
    logic [DATA_W-1:0] a_q, a_d;
    logic [DATA_W-1:0] b_q, b_d;
    logic [DATA_W-1:0] alu_r_q, alu_r_d;
    logic              zf_q, zf_d;
    logic              halted_q, halted_d;

    logic [DATA_W-1:0] op_a, op_b, alu_result;
    logic              alu_zero;

    assign c = ctrl_t'(ctrl);

`ifdef CPU_SINGLE_STEP_EN
    assign en = step;
`else
    assign en = 1'b1;
`endif

    // A halt request blocks writes in its own cycle, not just after halted is set
    assign blocked = c.halt | halted_q;
    assign wr_en   = en & ~blocked;

    assign mem_addr  = c.addr_sel ? ADDR_W'(b_q) + ADDR_W'(c.addr_offset) : pc_q;
    assign mem_wdata = c.mem_sel ? b_q : a_q;
    assign mem_wr    = c.mem_we & wr_en;

    assign op_a = c.alu_sel_a ? DATA_W'(pc_q) : a_q;
    assign op_b = c.alu_sel_b ? DATA_W'(ir_q[3:0]) : b_q;

    cpu_alu #(.DATA_W(DATA_W)) u_alu (
        .op_a   (op_a),
        .op_b   (op_b),
        .opcode (c.alu_opcode),
        .result (alu_result),
        .zero   (alu_zero)
    );

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        ir_d     = ir_q;
        a_d      = a_q;
        b_d      = b_q;
        alu_r_d  = alu_r_q;
        zf_d     = zf_q;
        halted_d = halted_q;
        if (en) begin
            state_d  = blocked ? HALT_STATE : next_state;
            halted_d = halted_q | c.halt;
        end
        if (wr_en) begin
            if (c.pc_we)
                pc_d = c.pc_sel ? pc_q + ADDR_W'($signed(c.pc_offset)) : pc_q + ADDR_W'(1);
            if (c.ir_we)
                ir_d = mem_rdata[7:0];
            if (c.alu_we)
                alu_r_d = alu_result;
            if (c.zf_we)
                zf_d = alu_zero;
            // A/B read the pre-edge ALU_R, so a same-cycle alu_we is not forwarded
            if (c.a_we)
                a_d = c.a_sel ? mem_rdata : alu_r_q;
            if (c.b_we)
                b_d = c.b_sel ? mem_rdata : alu_r_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= FETCH;
            pc_q     <= ADDR_W'(RESET_PC);
            ir_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            alu_r_q  <= '0;
            zf_q     <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            ir_q     <= ir_d;
            a_q      <= a_d;
            b_q      <= b_d;
            alu_r_q  <= alu_r_d;
            zf_q     <= zf_d;
            halted_q <= halted_d;
        end
    end

    assign state  = state_q;
    assign instr  = ir_q;
    assign zf     = zf_q;
    assign halted = halted_q;

endmodule

// File: tb/tb_cpu_datapath.sv
// Randomized and directed checks of cpu_datapath against an integer-level behavioural model.
module tb_cpu_datapath;

    localparam logic [25:0] PC_WE    = 26'd1 << 25;
    localparam logic [25:0] PC_SEL   = 26'd1 << 24;
    localparam logic [25:0] ADDR_SEL = 26'd1 << 19;
    localparam logic [25:0] MEM_SEL  = 26'd1 << 14;
    localparam logic [25:0] MEM_WE   = 26'd1 << 13;
    localparam logic [25:0] ALU_WE   = 26'd1 << 7;
    localparam logic [25:0] ZF_WE    = 26'd1 << 6;
    localparam logic [25:0] IR_WE    = 26'd1 << 5;
    localparam logic [25:0] A_SEL    = 26'd1 << 4;
    localparam logic [25:0] A_WE     = 26'd1 << 3;
    localparam logic [25:0] B_SEL    = 26'd1 << 2;
    localparam logic [25:0] B_WE     = 26'd1 << 1;
    localparam logic [25:0] HALT     = 26'd1;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  next_state;
    logic [25:0] ctrl;
    logic [2:0]  state;
    logic [7:0]  instr;
    logic        zf;
    logic [7:0]  mem_addr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;
    logic        mem_wr;
    logic        halted;
`ifdef CPU_SINGLE_STEP_EN
    logic        step;
`endif

    int checks = 0;
    int errors = 0;

    // behavioural model state
    int m_pc, m_ir, m_a, m_b, m_alu, m_zf, m_state, m_halted, m_en;

    cpu_datapath dut (
        .clk        (clk),
        .reset      (reset),
        .next_state (next_state),
        .ctrl       (ctrl),
        .state      (state),
        .instr      (instr),
        .zf         (zf),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
`ifdef CPU_SINGLE_STEP_EN
        .step       (step),
`endif
        .mem_wr     (mem_wr),
        .halted     (halted)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [25:0] pc_off(input int v);
        return 26'(v & 15) << 20;
    endfunction

    function automatic logic [25:0] addr_off(input int v);
        return 26'(v & 15) << 15;
    endfunction

    function automatic logic [25:0] alu_op(input int v);
        return 26'(v & 7) << 10;
    endfunction

    function automatic int alu_model(input int op, input int x, input int y);
        case (op)
            0: return (x + y) % 256;
            1: return (x - y) & 255;
            2: return x & y;
            3: return x | y;
            4: return x ^ y;
            5: return 255 - x;
            6: return (x * 2) % 256;
            default: return x / 2;
        endcase
    endfunction

    // Apply inputs between edges and check the combinational outputs against the model
    task automatic set_in(input logic [25:0] c, input logic [7:0] rd, input logic [2:0] ns,
                          input logic rst, input logic stp);
        int e_addr, e_wd, e_wr;
        ctrl       = c;
        mem_rdata  = rd;
        next_state = ns;
        reset      = rst;
        m_en       = int'(stp);
`ifdef CPU_SINGLE_STEP_EN
        step       = stp;
`endif
        #1;
        e_addr = c[19] ? (m_b + int'(c[18:15])) % 256 : m_pc;
        e_wd   = c[14] ? m_b : m_a;
        e_wr   = (c[13] && !c[0] && m_halted == 0 && m_en != 0) ? 1 : 0;
        check("mem_addr", 32'(mem_addr), 32'(e_addr));
        check("mem_wdata", 32'(mem_wdata), 32'(e_wd));
        check("mem_wr", 32'(mem_wr), 32'(e_wr));
    endtask

    task automatic model_edge();
        int opa, opb, res, off;
        int n_pc, n_ir, n_a, n_b, n_alu, n_zf;
        if (reset) begin
            m_pc = 0; m_ir = 0; m_a = 0; m_b = 0; m_alu = 0; m_zf = 0; m_state = 0; m_halted = 0;
        end else if (m_en != 0) begin
            if (ctrl[0] || m_halted != 0) begin
                m_state  = 5;
                m_halted = 1;
            end else begin
                m_state = int'(next_state);
                opa = ctrl[9] ? m_pc : m_a;
                opb = ctrl[8] ? (m_ir % 16) : m_b;
                res = alu_model(int'(ctrl[12:10]), opa, opb);
                off = int'(ctrl[23:20]);
                if (off >= 8) off -= 16;
                n_pc = m_pc; n_ir = m_ir; n_a = m_a; n_b = m_b; n_alu = m_alu; n_zf = m_zf;
                if (ctrl[25]) n_pc = ctrl[24] ? (m_pc + off + 256) % 256 : (m_pc + 1) % 256;
                if (ctrl[5])  n_ir = int'(mem_rdata);
                if (ctrl[7])  n_alu = res;
                if (ctrl[6])  n_zf = (res == 0) ? 1 : 0;
                if (ctrl[3])  n_a = ctrl[4] ? int'(mem_rdata) : m_alu;
                if (ctrl[1])  n_b = ctrl[2] ? int'(mem_rdata) : m_alu;
                m_pc = n_pc; m_ir = n_ir; m_a = n_a; m_b = n_b; m_alu = n_alu; m_zf = n_zf;
            end
        end
    endtask

    task automatic clock_edge();
        @(posedge clk);
        model_edge();
        #1;
        check("state", 32'(state), 32'(m_state));
        check("instr", 32'(instr), 32'(m_ir));
        check("zf", 32'(zf), 32'(m_zf));
        check("halted", 32'(halted), 32'(m_halted));
    endtask

    task automatic step_cycle(input string name, input logic [25:0] c, input logic [7:0] rd);
        set_in(c, rd, 3'd1, 1'b0, 1'b1);
        clock_edge();
        $display("%-12s ctrl=%h rd=%h -> state=%0d ir=%h zf=%b halted=%b",
                 name, c, rd, state, instr, zf, halted);
    endtask

    initial begin
        logic [25:0] rc;
        logic        rr, rs;
        m_pc = 0; m_ir = 0; m_a = 0; m_b = 0; m_alu = 0; m_zf = 0; m_state = 0; m_halted = 0; m_en = 1;

        // reset with every control bit asserted
        for (int i = 0; i < 2; i++) begin
            set_in('1, 8'hFF, 3'd7, 1'b1, 1'b1);
            check("rst_mem_wr", 32'(mem_wr), 32'd0);
            clock_edge();
            $display("reset        cycle %0d state=%0d halted=%b", i, state, halted);
        end
        check("rst_state", 32'(state), 32'd0);
        check("rst_ir", 32'(instr), 32'd0);
        check("rst_zf", 32'(zf), 32'd0);
        check("rst_halted", 32'(halted), 32'd0);
        set_in(26'd0, 8'h00, 3'd0, 1'b0, 1'b1);
        check("rst_pc", 32'(mem_addr), 32'd0);
        check("rst_a", 32'(mem_wdata), 32'd0);

        step_cycle("fetch", IR_WE | PC_WE, 8'h2A);
        check("ir_load", 32'(instr), 32'h2A);
        set_in(26'd0, 8'h00, 3'd0, 1'b0, 1'b1);
        check("pc_inc", 32'(mem_addr), 32'h01);

        step_cycle("load_a", A_WE | A_SEL, 8'h05);
        step_cycle("load_b", B_WE | B_SEL, 8'h05);
        step_cycle("sub", ALU_WE | ZF_WE | alu_op(1), 8'h00);
        check("sub_zf", 32'(zf), 32'd1);
        step_cycle("a_from_alu", A_WE, 8'h00);
        set_in(26'd0, 8'h00, 3'd0, 1'b0, 1'b1);
        check("a_zero", 32'(mem_wdata), 32'h00);

        // same-cycle alu_we + a_we takes the old ALU_R
        step_cycle("load_a", A_WE | A_SEL, 8'h09);
        step_cycle("add", ALU_WE | alu_op(0), 8'h00);
        step_cycle("sub_a_we", ALU_WE | A_WE | alu_op(1), 8'h00);
        set_in(26'd0, 8'h00, 3'd0, 1'b0, 1'b1);
        check("a_old_alu", 32'(mem_wdata), 32'h0E);

        step_cycle("pc_back", PC_WE | PC_SEL | pc_off(14), 8'h00);
        set_in(26'd0, 8'h00, 3'd0, 1'b0, 1'b1);
        check("pc_ff", 32'(mem_addr), 32'hFF);
        step_cycle("pc_wrap", PC_WE, 8'h00);
        set_in(26'd0, 8'h00, 3'd0, 1'b0, 1'b1);
        check("pc_wrap", 32'(mem_addr), 32'h00);
        step_cycle("pc_inc", PC_WE, 8'h00);
        step_cycle("pc_inc", PC_WE, 8'h00);
        step_cycle("pc_neg", PC_WE | PC_SEL | pc_off(14), 8'h00);
        set_in(26'd0, 8'h00, 3'd0, 1'b0, 1'b1);
        check("pc_sext", 32'(mem_addr), 32'h00);

        step_cycle("load_b", B_WE | B_SEL, 8'hFE);
        step_cycle("load_a", A_WE | A_SEL, 8'h77);
        set_in(ADDR_SEL | addr_off(3) | MEM_WE, 8'h00, 3'd2, 1'b0, 1'b1);
        check("st_addr", 32'(mem_addr), 32'h01);
        check("st_wdata", 32'(mem_wdata), 32'h77);
        check("st_wr", 32'(mem_wr), 32'd1);
        clock_edge();

        set_in(HALT | A_WE | A_SEL | MEM_WE, 8'h33, 3'd2, 1'b0, 1'b1);
        check("halt_wr", 32'(mem_wr), 32'd0);
        clock_edge();
        $display("halt         state=%0d halted=%b", state, halted);
        check("halt_state", 32'(state), 32'd5);
        check("halt_flag", 32'(halted), 32'd1);
        for (int i = 0; i < 3; i++) begin
            set_in(A_WE | A_SEL | MEM_WE | PC_WE, 8'h44, 3'd3, 1'b0, 1'b1);
            check("halted_wr", 32'(mem_wr), 32'd0);
            check("halted_a", 32'(mem_wdata), 32'h77);
            clock_edge();
            check("halted_state", 32'(state), 32'd5);
        end
        set_in(26'd0, 8'h00, 3'd0, 1'b1, 1'b1);
        clock_edge();
        check("unhalt", 32'(halted), 32'd0);

        // randomized phase
        for (int n = 0; n < 600; n++) begin
            rc = 26'($urandom);
            rc[0] = ($urandom_range(0, 99) == 0);
            rr = ($urandom_range(0, 59) == 0);
`ifdef CPU_SINGLE_STEP_EN
            rs = ($urandom_range(0, 3) != 0);
`else
            rs = 1'b1;
`endif
            set_in(rc, 8'($urandom), 3'($urandom), rr, rs);
            clock_edge();
            $display("rand %4d    ctrl=%h rst=%b en=%b addr=%h wd=%h wr=%b state=%0d halted=%b",
                     n, rc, rr, rs, mem_addr, mem_wdata, mem_wr, state, halted);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
